seq_unsigned_divider: RTL and testbench



---
 rtl/seq_unsigned_divider.sv | 132 +++++++++++++
 tb/tb_seq_unsigned_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_unsigned_divider.sv
// seq_unsigned_divider: sequential restoring divider, one quotient bit per clock.
// Start/ready handshake matches the shift-add multiplier. Results appear WIDTH
// cycles after an accepted start and are held until the next accepted start.
// Optional build macro: SEQ_DIV_ZERO_EARLY_EN. When it is defined, a zero
// divisor completes on the cycle after start instead of running all WIDTH steps.
//
// state | meaning
// IDLE  | no division in progress; outputs hold the last result
// RUN   | shifting/subtracting one quotient bit per clock
module seq_unsigned_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] d_work;
    logic [WIDTH:0]   r_work;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             zero_early;
    logic             last_step;
    logic             done;

`ifdef SEQ_DIV_ZERO_EARLY_EN
    assign zero_early = (d_work == '0);
`else
    assign zero_early = 1'b0;
`endif

    assign last_step = (cnt == CNT_ONE);
    assign done      = (state == RUN) && !start && (last_step || zero_early);

    // One restoring step: shift the next dividend bit into R, subtract D if it fits.
    always_comb begin
        r_shift = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
        q_next  = {q_work[WIDTH-2:0], 1'b0};
        r_next  = r_shift;
        if (r_shift >= {1'b0, d_work}) begin
            r_next    = r_shift - {1'b0, d_work};
            q_next[0] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start always (re)enters RUN, even mid-division.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = RUN;
        end else if (done) begin
            state_next = IDLE;
        end
    end

    // Working registers, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_work      <= '0;
            d_work      <= '0;
            r_work      <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            q_work      <= dividend;
            d_work      <= divisor;
            r_work      <= '0;
            cnt         <= CNT_INIT;
            ready       <= 1'b0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            if (zero_early) begin
                // q_work still holds the untouched dividend here.
                cnt         <= '0;
                quotient    <= '1;
                remainder   <= q_work;
                ready       <= 1'b1;
                busy        <= 1'b0;
                div_by_zero <= 1'b1;
            end else begin
                q_work <= q_next;
                r_work <= r_next;
                cnt    <= cnt - CNT_ONE;
                if (last_step) begin
                    quotient    <= q_next;
                    remainder   <= r_next[WIDTH-1:0];
                    ready       <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= (d_work == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// tb_seq_unsigned_divider: directed and randomized checks of seq_unsigned_divider
// against plain integer division.
module tb_seq_unsigned_divider;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             start;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_unsigned_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample/drive 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int lat);
        lat = WIDTH;
        if (b == 0) begin
            q = (1 << WIDTH) - 1;
            r = a;
`ifdef SEQ_DIV_ZERO_EARLY_EN
            lat = 1;
`endif
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_op(input int a, input int b, input string tag);
        int eq, er, lat, cyc, busy_cnt;
        ref_div(a, b, eq, er, lat);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        step();
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        check_val({tag, "_ready_low"}, 32'(ready), 0);
        cyc = 0;
        do begin
            step();
            cyc++;
            if (busy) busy_cnt++;
        end while (!ready && cyc < 40);
        check_val({tag, "_latency"}, cyc, lat);
        check_val({tag, "_busy_cycles"}, busy_cnt, lat);
        check_val({tag, "_q"}, 32'(quotient), eq);
        check_val({tag, "_r"}, 32'(remainder), er);
        check_val({tag, "_dbz"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
        check_val({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int a, b, rises, first_at;
        logic prev;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) step();
        check_val("reset_outs", {quotient, remainder, ready, busy, div_by_zero}, 0);
        rst_n = 1'b1;
        step();

        // Basic division, then hold while idle.
        run_op(100, 7, "basic");
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("hold", {ready, div_by_zero, quotient, remainder}, {2'b10, 8'd14, 8'd2});
        end

        // Boundary operands, each started as soon as the previous ready is seen.
        run_op(255, 1, "b255_1");
        run_op(5, 200, "b5_200");
        run_op(0, 9, "b0_9");
        run_op(255, 255, "b255_255");

        // Divide by zero, then a normal op clears the flag.
        run_op(77, 0, "dz77");
        run_op(10, 3, "after_dz");

        // Restart mid-operation.
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        step();
        start = 1'b0;
        check_val("restart_ready_low", 32'(ready), 0);
        rises    = 0;
        first_at = -1;
        prev     = ready;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ready && !prev) begin
                rises++;
                if (first_at < 0) first_at = i;
            end
            prev = ready;
        end
        check_val("restart_rises", rises, 1);
        check_val("restart_latency", first_at, WIDTH);
        check_val("restart_q", 32'(quotient), 8);
        check_val("restart_r", 32'(remainder), 2);

        // Reset mid-operation.
        dividend = 8'd123;
        divisor  = 8'd4;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        check_val("midreset_outs", {quotient, remainder, ready, busy, div_by_zero}, 0);
        rst_n = 1'b1;
        step();
        check_val("midreset_idle", {ready, busy}, 0);
        run_op(123, 4, "post_reset");

        // Randomized nonzero divisors.
        for (int n = 0; n < 1000; n++) begin
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = int'($urandom_range(1, (1 << WIDTH) - 1));
            run_op(a, b, "rand");
            check_val("rand_identity", int'(quotient) * b + int'(remainder), a);
            check_val("rand_rem_lt", (int'(remainder) < b) ? 1 : 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
